// File: rtl/commit_unit.sv
// In-order retirement at the ROB head: RF write and status clear are registered one cycle after a pop, stores go to the store buffer, and faults become a trap followed by a flush.
// Combinational pop handshake; the ROB is held off while in TRAP and while the store buffer stalls a store.
// Optional LEN5_COMMIT_INSTRET_EN adds a 64-bit retired-instruction counter on instret_o.
module commit_unit #(
    parameter int XLEN        = 64,
    parameter int ROB_IDX_LEN = 4,
    parameter int REG_IDX_LEN = 5
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   rob_valid_i,
    output logic                   rob_ready_o,
    input  logic [31:0]            rob_instr_i,
    input  logic [XLEN-1:0]        rob_pc_i,
    input  logic [REG_IDX_LEN-1:0] rob_rd_idx_i,
    input  logic [XLEN-1:0]        rob_value_i,
    input  logic                   rob_except_raised_i,
    input  logic [3:0]             rob_except_code_i,
    input  logic [ROB_IDX_LEN-1:0] rob_head_idx_i,
    output logic                   sb_commit_valid_o,
    input  logic                   sb_commit_ready_i,
    output logic                   rf_wr_en_o,
    output logic [REG_IDX_LEN-1:0] rf_wr_idx_o,
    output logic [XLEN-1:0]        rf_wr_value_o,
    output logic                   rs_clr_o,
    output logic [ROB_IDX_LEN-1:0] rs_clr_rob_idx_o,
    output logic                   except_valid_o,
    input  logic                   except_ready_i,
    output logic [3:0]             except_code_o,
    output logic [XLEN-1:0]        except_pc_o,
    output logic [XLEN-1:0]        except_tval_o,
    output logic                   flush_o
`ifdef LEN5_COMMIT_INSTRET_EN
    ,
    output logic [63:0]            instret_o
`endif
);

    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic {RUN, TRAP} state_t;

    state_t state_q, state_d;

    logic [6:0] opcode;
    logic       is_store, writes_rd, rd_nonzero, pop, retire;

    logic                   rf_wr_en_q;
    logic [REG_IDX_LEN-1:0] rf_wr_idx_q;
    logic [XLEN-1:0]        rf_wr_value_q;
    logic                   rs_clr_q;
    logic [ROB_IDX_LEN-1:0] rs_clr_rob_idx_q;
    logic [3:0]             exc_code_q;
    logic [XLEN-1:0]        exc_pc_q;
    logic [XLEN-1:0]        exc_tval_q;

    logic unused_instr_bits;
    assign unused_instr_bits = &{1'b0, rob_instr_i[31:7]};

    assign opcode     = rob_instr_i[6:0];
    assign is_store   = (opcode == OP_STORE);
    assign writes_rd  = !(is_store || opcode == OP_BRANCH || opcode == OP_SYSTEM);
    assign rd_nonzero = (rob_rd_idx_i != '0);
    assign pop        = rob_valid_i && rob_ready_o;
    assign retire     = pop && !rob_except_raised_i;

    always_comb begin
        state_d           = state_q;
        rob_ready_o       = 1'b0;
        sb_commit_valid_o = 1'b0;
        except_valid_o    = 1'b0;
        flush_o           = 1'b0;
        case (state_q)
            RUN: begin
                // Gated by reset so the handshake outputs read 0 while reset is held.
                if (rob_valid_i && !rst_i) begin
                    if (rob_except_raised_i) begin
                        rob_ready_o = 1'b1;
                        state_d     = TRAP;
                    end else if (is_store) begin
                        sb_commit_valid_o = 1'b1;
                        rob_ready_o       = sb_commit_ready_i;
                    end else begin
                        rob_ready_o = 1'b1;
                    end
                end
            end
            TRAP: begin
                except_valid_o = 1'b1;
                flush_o        = except_ready_i;
                if (except_ready_i) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q          <= RUN;
            rf_wr_en_q       <= 1'b0;
            rf_wr_idx_q      <= '0;
            rf_wr_value_q    <= '0;
            rs_clr_q         <= 1'b0;
            rs_clr_rob_idx_q <= '0;
            exc_code_q       <= '0;
            exc_pc_q         <= '0;
            exc_tval_q       <= '0;
        end else begin
            state_q    <= state_d;
            rf_wr_en_q <= retire && writes_rd && rd_nonzero;
            // Status clear follows any non-faulting pop with rd != 0, even for non-writers.
            rs_clr_q   <= retire && rd_nonzero;
            if (retire) begin
                rf_wr_idx_q      <= rob_rd_idx_i;
                rf_wr_value_q    <= rob_value_i;
                rs_clr_rob_idx_q <= rob_head_idx_i;
            end
            if (pop && rob_except_raised_i) begin
                exc_code_q <= rob_except_code_i;
                exc_pc_q   <= rob_pc_i;
                exc_tval_q <= rob_value_i;
            end
        end
    end

    assign rf_wr_en_o       = rf_wr_en_q;
    assign rf_wr_idx_o      = rf_wr_idx_q;
    assign rf_wr_value_o    = rf_wr_value_q;
    assign rs_clr_o         = rs_clr_q;
    assign rs_clr_rob_idx_o = rs_clr_rob_idx_q;
    assign except_code_o    = exc_code_q;
    assign except_pc_o      = exc_pc_q;
    assign except_tval_o    = exc_tval_q;

`ifdef LEN5_COMMIT_INSTRET_EN
    logic [63:0] instret_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)       instret_q <= '0;
        else if (retire) instret_q <= instret_q + 64'd1;
    end

    assign instret_o = instret_q;
`endif

endmodule
